// File: rtl/mpadder_arbiter_if.sv
// Bundle between the two Montgomery requesters and the shared-adder arbiter.
// Handshake: req is a level held until its done pulse; done is the one-cycle valid for result; req must drop in the done cycle.
interface mpadder_arbiter_if #(
  parameter int CNT_W = 32
);
  logic             req0;
  logic             sub0;
  logic [1027:0]    a0;
  logic [1027:0]    b0;
  logic             req1;
  logic             sub1;
  logic [1027:0]    a1;
  logic [1027:0]    b1;
  logic             done0;
  logic             done1;
  logic [1028:0]    result;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  logic [2:0]       state_dbg;

  modport master (
    output req0, sub0, a0, b0, req1, sub1, a1, b1,
    input  done0, done1, result, busy, op_count, state_dbg
  );

  modport slave (
    input  req0, sub0, a0, b0, req1, sub1, a1, b1,
    output done0, done1, result, busy, op_count, state_dbg
  );
endinterface

// File: rtl/mpadder_arbiter.sv
// Two-port arbiter around one registered 1028-bit carry-select adder; subtraction runs as a + ~b, then + 1.
// Optional completed-operation counter enabled by defining MPADD_ARB_OPCNT_EN.
module mpadder_arbiter #(
  parameter int RR_EN = 1,
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               reset,
  mpadder_arbiter_if.slave  bus
);

  localparam int W    = 1028;
  localparam int BLK  = 257;
  localparam int NBLK = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD1 = 3'd1,
    CAP1 = 3'd2,
    ADD2 = 3'd3,
    CAP2 = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic           sel_q, sel_d;
  logic           is_sub_q, is_sub_d;
  logic           last_grant_q, last_grant_d;
  logic           tmp_c_q, tmp_c_d;
  logic [W:0]     result_q, result_d;
  logic           done0_q, done0_d;
  logic           done1_q, done1_d;
  logic [W:0]     sum_q, sum_d;
  logic           pick_c;

  logic [BLK:0]   blk_s0 [NBLK];
  logic [BLK:0]   blk_s1 [NBLK];
  logic [W-1:0]   sum_c;
  logic           csel_c;

  // Each block precomputes both carry-in cases; the block carry chain only drives muxes.
  for (genvar k = 0; k < NBLK; k++) begin : g_csel
    assign blk_s0[k] = {1'b0, op_a_q[k*BLK +: BLK]} + {1'b0, op_b_q[k*BLK +: BLK]};
    assign blk_s1[k] = blk_s0[k] + {{BLK{1'b0}}, 1'b1};
  end

  always_comb begin
    csel_c = 1'b0;
    sum_c  = '0;
    for (int k = 0; k < NBLK; k++) begin
      sum_c[k*BLK +: BLK] = csel_c ? blk_s1[k][BLK-1:0] : blk_s0[k][BLK-1:0];
      csel_c              = csel_c ? blk_s1[k][BLK]     : blk_s0[k][BLK];
    end
    sum_d = {csel_c, sum_c};
  end

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    sel_d        = sel_q;
    is_sub_d     = is_sub_q;
    last_grant_d = last_grant_q;
    tmp_c_d      = tmp_c_q;
    result_d     = result_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    pick_c       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          if (bus.req0 && bus.req1) begin
            pick_c = (RR_EN != 0) ? ~last_grant_q : 1'b0;
          end else begin
            pick_c = bus.req1;
          end
          op_a_d       = pick_c ? bus.a1 : bus.a0;
          is_sub_d     = pick_c ? bus.sub1 : bus.sub0;
          if (pick_c) begin
            op_b_d = bus.sub1 ? ~bus.b1 : bus.b1;
          end else begin
            op_b_d = bus.sub0 ? ~bus.b0 : bus.b0;
          end
          sel_d        = pick_c;
          last_grant_d = pick_c;
          state_d      = ADD1;
        end
      end
      ADD1: state_d = CAP1;
      CAP1: begin
        if (!is_sub_q) begin
          result_d = sum_q;
          done0_d  = ~sel_q;
          done1_d  = sel_q;
          state_d  = IDLE;
        end else begin
          // Second pass adds the +1 of the two's complement; its carry merges with the first.
          tmp_c_d = sum_q[W];
          op_a_d  = sum_q[W-1:0];
          op_b_d  = {{(W-1){1'b0}}, 1'b1};
          state_d = ADD2;
        end
      end
      ADD2: state_d = CAP2;
      CAP2: begin
        result_d = {tmp_c_q | sum_q[W], sum_q[W-1:0]};
        done0_d  = ~sel_q;
        done1_d  = sel_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      sel_q        <= 1'b0;
      is_sub_q     <= 1'b0;
      last_grant_q <= 1'b1;
      tmp_c_q      <= 1'b0;
      result_q     <= '0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      sum_q        <= '0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      sel_q        <= sel_d;
      is_sub_q     <= is_sub_d;
      last_grant_q <= last_grant_d;
      tmp_c_q      <= tmp_c_d;
      result_q     <= result_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      sum_q        <= sum_d;
    end
  end

`ifdef MPADD_ARB_OPCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (done0_d || done1_d) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.op_count = cnt_q;
`else
  assign bus.op_count = '0;
`endif

  assign bus.done0     = done0_q;
  assign bus.done1     = done1_q;
  assign bus.result    = result_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.state_dbg = state_q;

endmodule

// File: doc/mpadder_arbiter.md
Name: mpadder_arbiter

Overview:
- Shares one mpadderB instance (1028-bit carry-select adder, one register stage) between two requesters in the Montgomery datapath, e.g. the multiply loop (port 0) and the final conditional subtraction (port 1).
- Holds the adder operands in registers and sequences each operation through the adder's register stage.
- Implements subtraction as two adder passes: a + ~b, then + 1.
- Returns the 1029-bit result with a per-port done pulse.

Parameters:
- RR_EN, 1: 1 = round-robin arbitration between ports; 0 = fixed priority, port 0 wins.
- CNT_W, 32: width of the completed-operation counter (optional feature).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req0  input  1  port 0 request; level, held until done0
- sub0  input  1  port 0: 0 = a+b, 1 = a-b
- a0  input  1028  port 0 operand A
- b0  input  1028  port 0 operand B
- req1, sub1, a1, b1: same as port 0, for port 1
- done0  output  1  one-cycle pulse, port 0 result valid
- done1  output  1  one-cycle pulse, port 1 result valid
- result  output  1029  shared result register
- busy  output  1  high whenever FSM is not IDLE
- op_count  output  CNT_W  completed operations (optional feature)

Behaviour:
- Reset values: done0 = 0, done1 = 0, result = 0, busy = 0, op_count = 0; FSM in IDLE; last_grant = 1, so port 0 wins the first tie.
- FSM states: IDLE, ADD1, CAP1, ADD2, CAP2.
- IDLE: at a clock edge with any req high:
  - Choose the port. RR_EN=1: on a tie, pick the port != last_grant. RR_EN=0: on a tie, pick port 0.
  - Latch op_a <= a, op_b <= (sub ? ~b : b), sel <= port, is_sub <= sub, last_grant <= port.
  - Go to ADD1. Call this acceptance edge E0.
- ADD1: adder inputs are op_a, op_b. At E1 the adder's internal registers capture; go to CAP1.
- CAP1 at E2:
  - Add: result <= adder result; pulse done[sel] in the cycle after E2; go to IDLE.
  - Sub: tmp_c <= adder bit1028; op_a <= adder[1027:0]; op_b <= 1; go to ADD2.
- ADD2: at E3 the adder captures; go to CAP2.
- CAP2 at E4: result[1027:0] <= adder[1027:0]; result[1028] <= tmp_c | adder[1028]; pulse done[sel] in the cycle after E4; go to IDLE.
- Latency: done high 2 cycles after E0 for add, 4 cycles after E0 for sub. Earliest next acceptance is the edge ending the done cycle, giving 3-cycle add throughput.
- Arithmetic:
  - Add: result = a + b, full 1029 bits.
  - Sub: result[1027:0] = (a - b) mod 2^1028; result[1028] = 1 iff a >= b (no borrow).
- result holds its value until the next capture; done0 and done1 are never high together.
- Requests:
  - A req dropped before acceptance is ignored.
  - A req dropped after acceptance: the operation completes and done still pulses.
  - Operand changes after E0 have no effect.
  - A requester must drop req in the done cycle, or it is treated as a new request.
- Reset asserted mid-operation: FSM to IDLE, no done pulse, result cleared to 0, op_count cleared.

Optional Feature:
- Macro: MPADD_ARB_OPCNT_EN.
- Defined: op_count increments by 1 on every done pulse (either port) and wraps 2^CNT_W-1 -> 0.
- Undefined: counter logic is absent and op_count is tied to 0.

Test Plan:
- Add: reset, then req0=1, sub0=0, a0=2^1028-1, b0=1 -> done0 2 cycles after acceptance; result = 2^1028 (bit1028 = 1, rest 0).
- Sub, no borrow: req1=1, sub1=1, a1=10, b1=3 -> done1 4 cycles after acceptance; result[1027:0] = 7, result[1028] = 1.
- Sub, borrow: a=3, b=10, sub=1 -> result[1027:0] = 2^1028-7, result[1028] = 0. Also a=b=5 -> result = 0 with bit1028 = 1.
- Round robin, RR_EN=1: req0 and req1 held high with distinct operands -> grants alternate 0,1,0,1 (port 0 first after reset); each done matches its own operands. With RR_EN=0 -> port 0 always wins while held.
- Reset mid-operation: assert reset in ADD2 of a sub -> no done; result = 0 and busy = 0 next cycle; a following add completes normally.
- With MPADD_ARB_OPCNT_EN: 5 operations -> op_count = 5. With CNT_W=4 and 17 operations -> op_count = 1. Without the macro -> op_count stays 0.
